// File: rtl/barrel_shift_pkg.sv
// Shared constants and the bit-reversal helper used by the barrel shifter datapath
// and by data_rev_mux.
package barrel_shift_pkg;

    localparam int unsigned BS_N     = 8;
    localparam int unsigned BS_MAX_N = 64;
    localparam int unsigned BS_IDX_W = $clog2(BS_MAX_N);

    // Reverses the low n bits of d; bits at and above n come back as zero.
    function automatic logic [BS_MAX_N-1:0] bs_reverse(input logic [BS_MAX_N-1:0] d,
                                                       input int unsigned n);
        logic [BS_MAX_N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < BS_MAX_N; i++) begin
            if (i < n) r[BS_IDX_W'(i)] = d[BS_IDX_W'(n - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/barrel_shift_pipe_if.sv
// Operand-in / result-out handshake bundle of the pipelined barrel shifter.
interface barrel_shift_pipe_if #(
    parameter int unsigned N   = barrel_shift_pkg::BS_N,
    parameter int unsigned SHW = $clog2(N)
) ();

    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   A_hat;
    logic           left;
    logic           arith;
    logic [SHW-1:0] shamt;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   Y;
    logic           out_left;

    modport master (
        output in_valid, A_hat, left, arith, shamt, out_ready,
        input  in_ready, out_valid, Y, out_left
    );

    modport slave (
        input  in_valid, A_hat, left, arith, shamt, out_ready,
        output in_ready, out_valid, Y, out_left
    );

endinterface

// File: rtl/data_rev_mux.sv
// Direction conditioning: passes the operand through, or bit-reverses it when left is set.
module data_rev_mux import barrel_shift_pkg::*; #(
    parameter int unsigned N = BS_N
) (
    input  logic [N-1:0] a_i,
    input  logic         left_i,
    output logic [N-1:0] a_hat_o
);

    logic [N-1:0] rev;

    assign rev     = N'(bs_reverse(BS_MAX_N'(a_i), N));
    assign a_hat_o = left_i ? rev : a_i;

endmodule

// File: rtl/shift_stage.sv
// One registered pipeline stage: conditional right shift by 2^K with fill, global enable.
module shift_stage #(
    parameter int unsigned N   = 8,
    parameter int unsigned K   = 0,
    parameter int unsigned SHW = $clog2(N)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           en_i,
    input  logic [N-1:0]   d_i,
    input  logic           v_i,
    input  logic           left_i,
    input  logic           fill_i,
    input  logic [SHW-1:0] shamt_i,
    output logic [N-1:0]   d_o,
    output logic           v_o,
    output logic           left_o,
    output logic           fill_o,
    output logic [SHW-1:0] shamt_o
);

    localparam int unsigned Step = 1 << K;

    logic [N-1:0] d_d;

    // shamt_i arrives pre-shifted so that bit 0 is always this stage's control bit.
    always_comb begin
        d_d = d_i;
        if (shamt_i[0]) d_d = {{Step{fill_i}}, d_i[N-1:Step]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            d_o     <= '0;
            v_o     <= 1'b0;
            left_o  <= 1'b0;
            fill_o  <= 1'b0;
            shamt_o <= '0;
        end else if (en_i) begin
            d_o     <= d_d;
            v_o     <= v_i;
            left_o  <= left_i;
            fill_o  <= fill_i;
            shamt_o <= shamt_i >> 1;
        end
    end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined right-shift core: SHW registered stages, global stall enable, output un-reversal.
module barrel_shift_pipe import barrel_shift_pkg::*; #(
    parameter int unsigned N   = BS_N,
    parameter int unsigned SHW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    barrel_shift_pipe_if.slave bus
);

    logic [N-1:0]   d_in     [SHW];
    logic           v_in     [SHW];
    logic           left_in  [SHW];
    logic           fill_in  [SHW];
    logic [SHW-1:0] shamt_in [SHW];

    logic [N-1:0]   d_q      [SHW];
    logic           v_q      [SHW];
    logic           left_q   [SHW];
    logic           fill_q   [SHW];
    logic [SHW-1:0] shamt_q  [SHW];

    logic adv;

    // Whole pipe advances together; bubbles are kept, never squeezed out.
    assign adv          = bus.out_ready | ~v_q[SHW-1];
    assign bus.in_ready = adv;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign d_in[k]     = bus.A_hat;
            assign v_in[k]     = bus.in_valid;
            assign left_in[k]  = bus.left;
            assign fill_in[k]  = bus.arith & ~bus.left & bus.A_hat[N-1];
            assign shamt_in[k] = bus.shamt;
        end else begin : g_tail
            assign d_in[k]     = d_q[k-1];
            assign v_in[k]     = v_q[k-1];
            assign left_in[k]  = left_q[k-1];
            assign fill_in[k]  = fill_q[k-1];
            assign shamt_in[k] = shamt_q[k-1];
        end

        shift_stage #(
            .N   (N),
            .K   (k),
            .SHW (SHW)
        ) u_stage (
            .clk_i   (clk),
            .rst_i   (rst),
            .en_i    (adv),
            .d_i     (d_in[k]),
            .v_i     (v_in[k]),
            .left_i  (left_in[k]),
            .fill_i  (fill_in[k]),
            .shamt_i (shamt_in[k]),
            .d_o     (d_q[k]),
            .v_o     (v_q[k]),
            .left_o  (left_q[k]),
            .fill_o  (fill_q[k]),
            .shamt_o (shamt_q[k])
        );
    end

    assign bus.out_valid = v_q[SHW-1];
    assign bus.out_left  = left_q[SHW-1];

    data_rev_mux #(
        .N (N)
    ) u_out_rev (
        .a_i     (d_q[SHW-1]),
        .left_i  (left_q[SHW-1]),
        .a_hat_o (bus.Y)
    );

endmodule
